// File: rtl/port_dev_pkg.sv
// rtl/port_dev_pkg.sv - shared widths, status bit positions and command bits for port_fifo_dev
package port_dev_pkg;

  localparam int WORD_W    = 16;
  localparam int CNT_W     = 4;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 8;

  localparam int ST_RX_EMPTY = 8;
  localparam int ST_TX_FULL  = 9;
  localparam int ST_TX_OVF   = 10;
  localparam int ST_RX_UDF   = 11;
  localparam int ST_IRQ      = 12;

  localparam int CMD_CLR   = 0;
  localparam int CMD_FLUSH = 1;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/port_fifo_dev_if.sv
// rtl/port_fifo_dev_if.sv - CPU port and device stream signals of one port_fifo_dev
// irq exists only when PORT_FIFO_IRQ_EN is defined.
interface port_fifo_dev_if;
  import port_dev_pkg::*;

  word_t cpu_data_in;
  word_t cpu_ctrl_in;
  logic  inform_write;
  logic  inform_read;
  word_t cpu_data_out;
  word_t cpu_status_out;
  logic  tx_valid;
  word_t tx_data;
  logic  tx_ready;
  logic  rx_valid;
  word_t rx_data;
  logic  rx_ready;
`ifdef PORT_FIFO_IRQ_EN
  logic  irq;
`endif

  modport slave (
    input  cpu_data_in, cpu_ctrl_in, inform_write, inform_read,
    input  tx_ready, rx_valid, rx_data,
    output cpu_data_out, cpu_status_out, tx_valid, tx_data, rx_ready
`ifdef PORT_FIFO_IRQ_EN
    , output irq
`endif
  );

  modport master (
    output cpu_data_in, cpu_ctrl_in, inform_write, inform_read,
    output tx_ready, rx_valid, rx_data,
    input  cpu_data_out, cpu_status_out, tx_valid, tx_data, rx_ready
`ifdef PORT_FIFO_IRQ_EN
    , input irq
`endif
  );

endinterface

// File: rtl/port_fifo.sv
// rtl/port_fifo.sv - synchronous FIFO with push/pop/flush and combinational head read
// A push on a full FIFO is accepted only when a pop frees the slot in the same cycle.
module port_fifo
  import port_dev_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  word_t push_data,
  input  logic  pop,
  input  logic  flush,
  output word_t head,
  output cnt_t  count,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  word_t            mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/port_fifo_dev.sv
// rtl/port_fifo_dev.sv - CPU I/O port responder with TX/RX FIFOs and a status word
// Optional feature macro: PORT_FIFO_IRQ_EN adds the irq output mirrored on status bit 12.
module port_fifo_dev
  import port_dev_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  port_fifo_dev_if.slave  bus
);

  word_t tx_head, rx_head;
  cnt_t  tx_count, rx_count;
  logic  tx_full, tx_empty, rx_full, rx_empty;
  logic  wr_flush, wr_clr, tx_push, tx_pop, rx_push, rx_pop;
  logic  ovf_evt, udf_evt;
  logic  tx_ovf, rx_udf, irq_q;

  assign wr_flush = bus.inform_write & bus.cpu_ctrl_in[CMD_FLUSH];
  assign wr_clr   = bus.inform_write & ~bus.cpu_ctrl_in[CMD_FLUSH] & bus.cpu_ctrl_in[CMD_CLR];
  assign tx_push  = bus.inform_write & ~bus.cpu_ctrl_in[CMD_FLUSH];
  assign tx_pop   = ~tx_empty & bus.tx_ready;
  assign rx_push  = bus.rx_valid & ~rx_full;
  assign rx_pop   = bus.inform_read;
  assign ovf_evt  = tx_push & tx_full & ~tx_pop;
  assign udf_evt  = bus.inform_read & rx_empty;

  port_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(tx_push), .push_data(bus.cpu_data_in), .pop(tx_pop), .flush(wr_flush),
    .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  port_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rx_push), .push_data(bus.rx_data), .pop(rx_pop), .flush(wr_flush),
    .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  // Clear happens before the push, so an overflow in the clearing write still sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      tx_ovf <= ovf_evt | (tx_ovf & ~wr_clr);
      rx_udf <= udf_evt | (rx_udf & ~wr_clr);
    end
  end

`ifdef PORT_FIFO_IRQ_EN
  logic irq_evt;
  assign irq_evt = ~wr_flush & ((rx_empty & rx_push) | (tx_full & tx_pop & ~tx_push));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_evt | (irq_q & ~wr_clr);
  end

  assign bus.irq = irq_q;
`else
  assign irq_q = 1'b0;
`endif

  always_comb begin
    bus.cpu_status_out              = '0;
    bus.cpu_status_out[3:0]         = rx_count;
    bus.cpu_status_out[7:4]         = tx_count;
    bus.cpu_status_out[ST_RX_EMPTY] = rx_empty;
    bus.cpu_status_out[ST_TX_FULL]  = tx_full;
    bus.cpu_status_out[ST_TX_OVF]   = tx_ovf;
    bus.cpu_status_out[ST_RX_UDF]   = rx_udf;
    bus.cpu_status_out[ST_IRQ]      = irq_q;
  end

  assign bus.cpu_data_out = rx_head;
  assign bus.tx_valid     = ~tx_empty;
  assign bus.tx_data      = tx_head;
  assign bus.rx_ready     = ~rx_full;

endmodule

// File: tb/tb_port_fifo_dev.sv
// tb/tb_port_fifo_dev.sv - table-driven and directed checks for port_fifo_dev
// Build with or without PORT_FIFO_IRQ_EN.
module tb_port_fifo_dev;

  typedef struct {
    logic        w;
    logic [15:0] ctrl;
    logic [15:0] d;
    logic        r;
    logic        txr;
    logic        rxv;
    logic [15:0] rxd;
    logic [15:0] st;
    logic [15:0] dout;
    logic        txv;
    logic [15:0] txd;
    logic        rxr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  port_fifo_dev_if bus_if ();

  port_fifo_dev #(.DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [15:0] ctrl, input logic [15:0] d,
                       input logic r, input logic txr, input logic rxv, input logic [15:0] rxd);
    bus_if.inform_write = w;
    bus_if.cpu_ctrl_in  = ctrl;
    bus_if.cpu_data_in  = d;
    bus_if.inform_read  = r;
    bus_if.tx_ready     = txr;
    bus_if.rx_valid     = rxv;
    bus_if.rx_data      = rxd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_irq(input string name, input logic exp);
`ifdef PORT_FIFO_IRQ_EN
    chk({name, " irq"}, {15'd0, bus_if.irq}, {15'd0, exp});
    chk({name, " st12"}, {15'd0, bus_if.cpu_status_out[12]}, {15'd0, exp});
`else
    chk({name, " st12"}, {15'd0, bus_if.cpu_status_out[12]}, 16'd0);
`endif
  endtask

  function automatic vec_t mk(logic w, logic [15:0] ctrl, logic [15:0] d, logic r, logic txr,
                              logic rxv, logic [15:0] rxd, logic [15:0] st, logic [15:0] dout,
                              logic txv, logic [15:0] txd, logic rxr);
    vec_t v;
    v.w = w; v.ctrl = ctrl; v.d = d; v.r = r; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
    v.st = st; v.dout = dout; v.txv = txv; v.txd = txd; v.rxr = rxr;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // TX path
    vecs.push_back(mk(1, 16'h0000, 16'hA001, 0, 0, 0, 16'h0, 16'h0110, 16'h0, 1, 16'hA001, 1));
    vecs.push_back(mk(1, 16'h0000, 16'hA002, 0, 0, 0, 16'h0, 16'h0120, 16'h0, 1, 16'hA001, 1));
    vecs.push_back(mk(1, 16'h0000, 16'hA003, 0, 0, 0, 16'h0, 16'h0130, 16'h0, 1, 16'hA001, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0, 16'h0120, 16'h0, 1, 16'hA002, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0, 16'h0110, 16'h0, 1, 16'hA003, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0, 16'h0100, 16'h0, 0, 16'h0000, 1));
    // TX fill to full, overflow, then simultaneous pop+push on full
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 16'h0, 16'hB000 + 16'(i), 0, 0, 0, 16'h0,
                        16'h0100 | 16'((i + 1) << 4) | (i == 7 ? 16'h0200 : 16'h0),
                        16'h0, 1, 16'hB000, 1));
    vecs.push_back(mk(1, 16'h0000, 16'hBEEF, 0, 0, 0, 16'h0, 16'h0780, 16'h0, 1, 16'hB000, 1));
    vecs.push_back(mk(1, 16'h0000, 16'hBEEF, 0, 1, 0, 16'h0, 16'h0780, 16'h0, 1, 16'hB001, 1));
    for (int j = 1; j <= 8; j++)
      vecs.push_back(mk(0, 16'h0, 16'h0, 0, 1, 0, 16'h0, 16'h0500 | 16'((8 - j) << 4), 16'h0,
                        j < 8, (j < 7) ? 16'hB001 + 16'(j) : ((j == 7) ? 16'hBEEF : 16'h0), 1));
    // clear flags and push in one write
    vecs.push_back(mk(1, 16'h0001, 16'hC001, 0, 0, 0, 16'h0, 16'h0110, 16'h0, 1, 16'hC001, 1));
    // RX path and underflow
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h1234, 16'h0011, 16'h1234, 1, 16'hC001, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h5678, 16'h0012, 16'h1234, 1, 16'hC001, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0, 16'h0011, 16'h5678, 1, 16'hC001, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0, 16'h0110, 16'h0000, 1, 16'hC001, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0, 16'h0910, 16'h0000, 1, 16'hC001, 1));
    vecs.push_back(mk(1, 16'h0001, 16'hC002, 0, 0, 0, 16'h0, 16'h0120, 16'h0000, 1, 16'hC001, 1));
    // flush beats concurrent device push and pop
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h9999, 16'h0021, 16'h9999, 1, 16'hC001, 1));
    vecs.push_back(mk(1, 16'h0002, 16'hDEAD, 0, 1, 1, 16'h7777, 16'h0100, 16'h0000, 0, 16'h0000, 1));
    // RX fill to full, then push refused, then pop/push on non-full
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 16'h0, 16'h0, 0, 0, 1, 16'h5000 + 16'(i), 16'(i + 1),
                        16'h5000, 0, 16'h0, i < 7));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 16'h1111, 16'h0008, 16'h5000, 0, 16'h0, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1, 16'h2222, 16'h0007, 16'h5001, 0, 16'h0, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1, 16'h3333, 16'h0007, 16'h5002, 0, 16'h0, 1));

    drive(0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    rst_n = 1'b0;
    #1;
    chk("reset status", bus_if.cpu_status_out, 16'h0100);
    chk("reset dout", bus_if.cpu_data_out, 16'h0000);
    chk("reset txv", {15'd0, bus_if.tx_valid}, 16'd0);
    chk("reset txd", bus_if.tx_data, 16'h0000);
    chk("reset rxr", {15'd0, bus_if.rx_ready}, 16'd1);
    chk_irq("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].w, vecs[i].ctrl, vecs[i].d, vecs[i].r, vecs[i].txr, vecs[i].rxv, vecs[i].rxd);
      tick();
      chk($sformatf("v%0d status", i), bus_if.cpu_status_out & 16'hEFFF, vecs[i].st);
      chk($sformatf("v%0d dout", i), bus_if.cpu_data_out, vecs[i].dout);
      chk($sformatf("v%0d txv", i), {15'd0, bus_if.tx_valid}, {15'd0, vecs[i].txv});
      chk($sformatf("v%0d txd", i), bus_if.tx_data, vecs[i].txd);
      chk($sformatf("v%0d rxr", i), {15'd0, bus_if.rx_ready}, {15'd0, vecs[i].rxr});
`ifdef PORT_FIFO_IRQ_EN
      chk($sformatf("v%0d irq mirror", i), {15'd0, bus_if.irq}, {15'd0, bus_if.cpu_status_out[12]});
`else
      chk($sformatf("v%0d st12", i), {15'd0, bus_if.cpu_status_out[12]}, 16'd0);
`endif
    end

    // irq set on first RX word, cleared by a clear command
    drive(1, 16'h0002, 16'h0, 0, 0, 0, 16'h0);
    tick();
    chk("irq flush status", bus_if.cpu_status_out & 16'hEFFF, 16'h0100);
    drive(1, 16'h0001, 16'hC0DE, 0, 0, 0, 16'h0);
    tick();
    chk_irq("irq clr1", 1'b0);
    drive(0, 16'h0, 16'h0, 0, 1, 0, 16'h0);
    tick();
    chk_irq("irq txdrain", 1'b0);
    drive(0, 16'h0, 16'h0, 0, 0, 1, 16'h4242);
    tick();
    chk_irq("irq rxfirst", 1'b1);
    chk("irq rx dout", bus_if.cpu_data_out, 16'h4242);
    drive(1, 16'h0001, 16'hC0DF, 0, 0, 0, 16'h0);
    tick();
    chk_irq("irq clr2", 1'b0);
    chk("irq clr2 status", bus_if.cpu_status_out & 16'hEFFF, 16'h0011);

    // asynchronous reset mid-cycle with a device push pending
    drive(0, 16'h0, 16'h0, 0, 0, 1, 16'h6666);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async status", bus_if.cpu_status_out, 16'h0100);
    chk("async txv", {15'd0, bus_if.tx_valid}, 16'd0);
    chk("async rxr", {15'd0, bus_if.rx_ready}, 16'd1);
    chk("async dout", bus_if.cpu_data_out, 16'h0000);
    tick();
    chk("held status", bus_if.cpu_status_out, 16'h0100);
    drive(0, 16'h0, 16'h0, 0, 0, 0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post reset status", bus_if.cpu_status_out, 16'h0100);
    chk_irq("post reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
